// File: rtl/cpu_pkg.sv
// cpu_pkg: shared op codes, register selects, flag bit positions and the
// output-stage state type for the CPU execute stage.
package cpu_pkg;

    localparam int OP_W      = 4;
    localparam int REG_SEL_W = 3;

    localparam int FLAG_Z = 7;
    localparam int FLAG_N = 6;
    localparam int FLAG_H = 5;
    localparam int FLAG_C = 4;

    typedef enum logic [OP_W-1:0] {
        ALU_ADD = 4'd0,
        ALU_ADC = 4'd1,
        ALU_SUB = 4'd2,
        ALU_SBC = 4'd3,
        ALU_AND = 4'd4,
        ALU_XOR = 4'd5,
        ALU_OR  = 4'd6,
        ALU_CP  = 4'd7,
        ALU_INC = 4'd8,
        ALU_DEC = 4'd9,
        ALU_RLC = 4'd10,
        ALU_RRC = 4'd11,
        ALU_RL  = 4'd12,
        ALU_RR  = 4'd13,
        ALU_CPL = 4'd14,
        ALU_DAA = 4'd15
    } alu_op_e;

    typedef enum logic [REG_SEL_W-1:0] {
        REG_B   = 3'd0,
        REG_C   = 3'd1,
        REG_D   = 3'd2,
        REG_E   = 3'd3,
        REG_H   = 3'd4,
        REG_L   = 3'd5,
        REG_HLM = 3'd6,
        REG_A   = 3'd7
    } reg_sel_e;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/cpu_alu_core.sv
// cpu_alu_core: purely combinational SM83 8-bit ALU (op, operands, F in -> result, F out).
// Op 15 performs DAA only when CPU_ALU_DAA_EN is defined; otherwise it is a NOP.
module cpu_alu_core
    import cpu_pkg::*;
(
    input  alu_op_e    op_i,
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic [7:4] flags_i,
    output logic [7:0] result_o,
    output logic [7:4] flags_o,
    output logic       wr_allowed_o
);

    logic [8:0] sum9;
    logic [4:0] nib5;
    logic       cin;
    logic       keepZ;
    logic       n;
    logic       h;
    logic       c;
`ifdef CPU_ALU_DAA_EN
    logic [7:0] daaCorr;
`endif

    always_comb begin
        result_o     = a_i;
        wr_allowed_o = 1'b1;
        keepZ        = 1'b0;
        n            = flags_i[FLAG_N];
        h            = flags_i[FLAG_H];
        c            = flags_i[FLAG_C];
        cin          = 1'b0;
        sum9         = '0;
        nib5         = '0;
`ifdef CPU_ALU_DAA_EN
        daaCorr      = '0;
`endif
        // 9-bit and 5-bit widened sums expose carry/borrow out of bit 7 and bit 3.
        unique case (op_i)
            ALU_ADD, ALU_ADC: begin
                cin      = (op_i == ALU_ADC) & flags_i[FLAG_C];
                sum9     = {1'b0, a_i} + {1'b0, b_i} + {8'h00, cin};
                nib5     = {1'b0, a_i[3:0]} + {1'b0, b_i[3:0]} + {4'h0, cin};
                result_o = sum9[7:0];
                n        = 1'b0;
                h        = nib5[4];
                c        = sum9[8];
            end
            ALU_SUB, ALU_SBC, ALU_CP: begin
                cin          = (op_i == ALU_SBC) & flags_i[FLAG_C];
                sum9         = {1'b0, a_i} - {1'b0, b_i} - {8'h00, cin};
                nib5         = {1'b0, a_i[3:0]} - {1'b0, b_i[3:0]} - {4'h0, cin};
                result_o     = sum9[7:0];
                n            = 1'b1;
                h            = nib5[4];
                c            = sum9[8];
                wr_allowed_o = (op_i != ALU_CP);
            end
            ALU_AND: begin
                result_o = a_i & b_i;
                n        = 1'b0;
                h        = 1'b1;
                c        = 1'b0;
            end
            ALU_XOR, ALU_OR: begin
                result_o = (op_i == ALU_XOR) ? (a_i ^ b_i) : (a_i | b_i);
                n        = 1'b0;
                h        = 1'b0;
                c        = 1'b0;
            end
            ALU_INC: begin
                nib5     = {1'b0, a_i[3:0]} + 5'd1;
                result_o = a_i + 8'd1;
                n        = 1'b0;
                h        = nib5[4];
            end
            ALU_DEC: begin
                nib5     = {1'b0, a_i[3:0]} - 5'd1;
                result_o = a_i - 8'd1;
                n        = 1'b1;
                h        = nib5[4];
            end
            ALU_RLC: begin
                result_o = {a_i[6:0], a_i[7]};
                n        = 1'b0;
                h        = 1'b0;
                c        = a_i[7];
            end
            ALU_RRC: begin
                result_o = {a_i[0], a_i[7:1]};
                n        = 1'b0;
                h        = 1'b0;
                c        = a_i[0];
            end
            ALU_RL: begin
                result_o = {a_i[6:0], flags_i[FLAG_C]};
                n        = 1'b0;
                h        = 1'b0;
                c        = a_i[7];
            end
            ALU_RR: begin
                result_o = {flags_i[FLAG_C], a_i[7:1]};
                n        = 1'b0;
                h        = 1'b0;
                c        = a_i[0];
            end
            ALU_CPL: begin
                result_o = ~a_i;
                n        = 1'b1;
                h        = 1'b1;
                keepZ    = 1'b1;
            end
            ALU_DAA: begin
`ifdef CPU_ALU_DAA_EN
                // Corrections are chosen from the original A, N, H and C.
                if (!flags_i[FLAG_N]) begin
                    if (flags_i[FLAG_C] || (a_i > 8'h99)) begin
                        daaCorr[7:4] = 4'h6;
                        c            = 1'b1;
                    end
                    if (flags_i[FLAG_H] || (a_i[3:0] > 4'h9)) begin
                        daaCorr[3:0] = 4'h6;
                    end
                    result_o = a_i + daaCorr;
                end else begin
                    if (flags_i[FLAG_C]) begin
                        daaCorr[7:4] = 4'h6;
                    end
                    if (flags_i[FLAG_H]) begin
                        daaCorr[3:0] = 4'h6;
                    end
                    result_o = a_i - daaCorr;
                end
                h = 1'b0;
`else
                keepZ = 1'b1;
`endif
            end
        endcase

        flags_o[FLAG_Z] = keepZ ? flags_i[FLAG_Z] : (result_o == 8'h00);
        flags_o[FLAG_N] = n;
        flags_o[FLAG_H] = h;
        flags_o[FLAG_C] = c;
    end

endmodule

// File: rtl/cpu_alu_stage.sv
// cpu_alu_stage: ALU execute stage with a one-entry output register, stall handshake
// and the architectural F register. Define CPU_ALU_DAA_EN to enable DAA on op 15.
module cpu_alu_stage
    import cpu_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [OP_W-1:0]      i_op,
    input  logic [7:0]           i_op_a,
    input  logic [7:0]           i_op_b,
    input  logic [REG_SEL_W-1:0] i_dst,
    input  logic                 i_stall,
    output logic [REG_SEL_W-1:0] o_reg_wr_sel,
    output logic                 o_reg_wr_en,
    output logic [7:0]           o_reg_wr_data,
    input  logic                 i_f_wr_en,
    input  logic [7:0]           i_f_wr_data,
    output logic [7:0]           o_flags
);

    out_state_e state_q;
    reg_sel_e   wr_sel_q;
    logic [7:0] wr_data_q;
    logic       wr_allowed_q;
    logic [7:4] flags_q;

    alu_op_e    op;
    logic [7:0] result_d;
    logic [7:4] flags_d;
    logic       wr_allowed_d;
    logic       accept;
    logic       unusedFLow;

    assign op         = alu_op_e'(i_op);
    assign unusedFLow = ^i_f_wr_data[3:0];

    cpu_alu_core u_core (
        .op_i         (op),
        .a_i          (i_op_a),
        .b_i          (i_op_b),
        .flags_i      (flags_q),
        .result_o     (result_d),
        .flags_o      (flags_d),
        .wr_allowed_o (wr_allowed_d)
    );

    assign o_ready = (state_q == OUT_EMPTY) || !i_stall;
    assign accept  = i_valid && o_ready;

    // F is updated at accept so a back-to-back ADC/SBC sees the previous op's carry.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q      <= OUT_EMPTY;
            wr_sel_q     <= REG_B;
            wr_data_q    <= '0;
            wr_allowed_q <= 1'b0;
            flags_q      <= '0;
        end else begin
            if (accept) begin
                state_q      <= OUT_FULL;
                wr_sel_q     <= reg_sel_e'(i_dst);
                wr_data_q    <= result_d;
                wr_allowed_q <= wr_allowed_d;
            end else if (!i_stall) begin
                state_q <= OUT_EMPTY;
            end

            if (i_f_wr_en) begin
                flags_q <= i_f_wr_data[7:4];
            end else if (accept) begin
                flags_q <= flags_d;
            end
        end
    end

    assign o_reg_wr_sel  = wr_sel_q;
    assign o_reg_wr_data = wr_data_q;
    assign o_reg_wr_en   = (state_q == OUT_FULL) && wr_allowed_q && !i_stall;
    assign o_flags       = {flags_q, 4'h0};

endmodule

// File: tb/tb_cpu_alu_stage.sv
// tb_cpu_alu_stage: directed plus randomized checks of cpu_alu_stage against
// an arithmetic reference model of the SM83 ALU and the output-stage handshake.
module tb_cpu_alu_stage;
    import cpu_pkg::*;

    logic       clk = 1'b0;
    logic       rstN;
    logic       valid;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] dst;
    logic       stall;
    logic       fwe;
    logic [7:0] fwd;

    logic       oReady;
    logic [2:0] oWrSel;
    logic       oWrEn;
    logic [7:0] oWrData;
    logic [7:0] oFlags;

    int checks   = 0;
    int failures = 0;

    // Reference state: what the stage should currently be presenting.
    bit       mValid;
    bit [7:0] mData;
    bit [2:0] mSel;
    bit       mWr;
    bit [7:0] mF;

    always #5 clk = ~clk;

    cpu_alu_stage dut (
        .i_clk         (clk),
        .i_rst         (rstN),
        .i_valid       (valid),
        .o_ready       (oReady),
        .i_op          (op),
        .i_op_a        (a),
        .i_op_b        (b),
        .i_dst         (dst),
        .i_stall       (stall),
        .o_reg_wr_sel  (oWrSel),
        .o_reg_wr_en   (oWrEn),
        .o_reg_wr_data (oWrData),
        .i_f_wr_en     (fwe),
        .i_f_wr_data   (fwd),
        .o_flags       (oFlags)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // SM83 ALU behaviour written with plain integer arithmetic.
    function automatic void aluModel(input int opI, input int aI, input int bI, input bit [7:0] f,
                                     output int res, output bit [7:0] fo, output bit wrOk);
        bit z, n, h, c, cf, zFromRes;
        int ci, outBit, adj;
        z = f[7]; n = f[6]; h = f[5]; c = f[4]; cf = f[4];
        zFromRes = 1; wrOk = 1; res = aI; ci = 0; outBit = 0; adj = 0;
        case (opI)
            0, 1: begin
                ci  = (opI == 1) ? int'(cf) : 0;
                res = (aI + bI + ci) % 256;
                n = 0; h = ((aI % 16) + (bI % 16) + ci) > 15; c = (aI + bI + ci) > 255;
            end
            2, 3, 7: begin
                ci  = (opI == 3) ? int'(cf) : 0;
                res = (aI - bI - ci + 256) % 256;
                n = 1; h = (aI % 16) < ((bI % 16) + ci); c = aI < (bI + ci);
                wrOk = (opI != 7);
            end
            4: begin res = aI & bI; n = 0; h = 1; c = 0; end
            5: begin res = aI ^ bI; n = 0; h = 0; c = 0; end
            6: begin res = aI | bI; n = 0; h = 0; c = 0; end
            8: begin res = (aI + 1) % 256; n = 0; h = (aI % 16) == 15; end
            9: begin res = (aI + 255) % 256; n = 1; h = (aI % 16) == 0; end
            10: begin outBit = aI / 128; res = (aI * 2) % 256 + outBit; c = outBit != 0; n = 0; h = 0; end
            11: begin outBit = aI % 2; res = aI / 2 + outBit * 128; c = outBit != 0; n = 0; h = 0; end
            12: begin outBit = aI / 128; res = (aI * 2) % 256 + int'(cf); c = outBit != 0; n = 0; h = 0; end
            13: begin outBit = aI % 2; res = aI / 2 + int'(cf) * 128; c = outBit != 0; n = 0; h = 0; end
            14: begin res = 255 - aI; n = 1; h = 1; zFromRes = 0; end
            default: begin
`ifdef CPU_ALU_DAA_EN
                if (!n) begin
                    if (c || aI > 153) begin adj += 96; c = 1; end
                    if (h || (aI % 16) > 9) adj += 6;
                    res = (aI + adj) % 256;
                end else begin
                    if (c) adj += 96;
                    if (h) adj += 6;
                    res = (aI - adj + 256) % 256;
                end
                h = 0;
`else
                res = aI;
                zFromRes = 0;
`endif
            end
        endcase
        if (zFromRes) z = (res == 0);
        fo = {z, n, h, c, 4'h0};
    endfunction

    // Drive one cycle's inputs and compare the settled outputs with the model.
    task automatic applyStimulus(input logic r, input logic v, input logic [3:0] o,
                                 input logic [7:0] aa, input logic [7:0] bb, input logic [2:0] d,
                                 input logic s, input logic fw, input logic [7:0] fd);
        rstN = r; valid = v; op = o; a = aa; b = bb; dst = d; stall = s; fwe = fw; fwd = fd;
        #2;
        checkOutput("ready",   32'(oReady),  32'(!mValid || !s));
        checkOutput("wr_en",   32'(oWrEn),   32'(mValid && mWr && !s));
        checkOutput("wr_sel",  32'(oWrSel),  32'(mSel));
        checkOutput("wr_data", 32'(oWrData), 32'(mData));
        checkOutput("flags",   32'(oFlags),  32'(mF));
    endtask

    // Advance the model by the current inputs, then cross the clock edge.
    task automatic stepClock(output bit accepted);
        int res;
        bit [7:0] fo;
        bit wrOk;
        accepted = 0;
        if (!rstN) begin
            mValid = 0; mData = 0; mSel = 0; mWr = 0; mF = 0;
        end else begin
            accepted = valid && (!mValid || !stall);
            if (accepted) begin
                aluModel(int'(op), int'(a), int'(b), mF, res, fo, wrOk);
                mValid = 1; mData = 8'(res); mSel = dst; mWr = wrOk;
            end else if (!stall) begin
                mValid = 0;
            end
            if (fwe) mF = {fwd[7:4], 4'h0};
            else if (accepted) mF = fo;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit acc, pending, r, v, s, fw;
        logic [3:0] hOp;
        logic [7:0] hA, hB, fd;
        logic [2:0] hDst;

        rstN = 0; valid = 0; op = 0; a = 0; b = 0; dst = 0; stall = 0; fwe = 0; fwd = 0;
        repeat (2) @(posedge clk);
        #1;
        mValid = 0; mData = 0; mSel = 0; mWr = 0; mF = 0;

        // Reset state, with a request and stall present that reset must override.
        applyStimulus(0, 1, 4'd0, 8'h12, 8'h34, 3'd5, 1, 1, 8'hFF);
        stepClock(acc);
        applyStimulus(1, 0, 4'd0, 8'h00, 8'h00, 3'd0, 0, 0, 8'h00);
        checkOutput("rst_wr_en", 32'(oWrEn), 32'd0);
        checkOutput("rst_flags", 32'(oFlags), 32'h00);
        checkOutput("rst_data", 32'(oWrData), 32'h00);

        // ADD 3A + C6 -> 00, Z H C.
        applyStimulus(1, 1, 4'd0, 8'h3A, 8'hC6, 3'd7, 0, 0, 8'h00);
        stepClock(acc);
        applyStimulus(1, 0, 4'd0, 8'h00, 8'h00, 3'd0, 0, 0, 8'h00);
        checkOutput("add_wr_en", 32'(oWrEn), 32'd1);
        checkOutput("add_sel", 32'(oWrSel), 32'd7);
        checkOutput("add_data", 32'(oWrData), 32'h00);
        checkOutput("add_flags", 32'(oFlags), 32'hB0);
        stepClock(acc);

        // ADD FF+01 then ADC 10+20 back-to-back, carry-in taken from the first op.
        applyStimulus(1, 1, 4'd0, 8'hFF, 8'h01, 3'd0, 0, 0, 8'h00);
        stepClock(acc);
        applyStimulus(1, 1, 4'd1, 8'h10, 8'h20, 3'd1, 0, 0, 8'h00);
        stepClock(acc);
        applyStimulus(1, 0, 4'd0, 8'h00, 8'h00, 3'd0, 0, 0, 8'h00);
        checkOutput("adc_data", 32'(oWrData), 32'h31);
        checkOutput("adc_flags", 32'(oFlags), 32'h00);
        stepClock(acc);

        // CP suppresses the write; SUB borrow sets N and C.
        applyStimulus(1, 1, 4'd7, 8'h10, 8'h10, 3'd2, 0, 0, 8'h00);
        stepClock(acc);
        applyStimulus(1, 1, 4'd2, 8'h10, 8'h20, 3'd3, 0, 0, 8'h00);
        checkOutput("cp_wr_en", 32'(oWrEn), 32'd0);
        checkOutput("cp_flags", 32'(oFlags), 32'hC0);
        stepClock(acc);
        applyStimulus(1, 0, 4'd0, 8'h00, 8'h00, 3'd0, 0, 0, 8'h00);
        checkOutput("sub_data", 32'(oWrData), 32'hF0);
        checkOutput("sub_flags", 32'(oFlags), 32'h50);
        checkOutput("sub_wr_en", 32'(oWrEn), 32'd1);
        stepClock(acc);

        // INC accepted under stall, held frozen three cycles, then released once.
        applyStimulus(1, 1, 4'd8, 8'h41, 8'h00, 3'd4, 1, 0, 8'h00);
        stepClock(acc);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 4'd0, 8'h00, 8'h00, 3'd0, 1, 0, 8'h00);
            checkOutput("stall_ready", 32'(oReady), 32'd0);
            checkOutput("stall_wr_en", 32'(oWrEn), 32'd0);
            checkOutput("stall_data", 32'(oWrData), 32'h42);
            stepClock(acc);
        end
        applyStimulus(1, 0, 4'd0, 8'h00, 8'h00, 3'd0, 0, 0, 8'h00);
        checkOutput("release_wr_en", 32'(oWrEn), 32'd1);
        checkOutput("release_data", 32'(oWrData), 32'h42);
        stepClock(acc);
        applyStimulus(1, 0, 4'd0, 8'h00, 8'h00, 3'd0, 0, 0, 8'h00);
        checkOutput("after_release_wr_en", 32'(oWrEn), 32'd0);
        stepClock(acc);

        // External F load wins over the coincident AND's flag update.
        applyStimulus(1, 1, 4'd4, 8'hF0, 8'h0F, 3'd6, 0, 1, 8'hFF);
        stepClock(acc);
        applyStimulus(1, 0, 4'd0, 8'h00, 8'h00, 3'd0, 0, 0, 8'h00);
        checkOutput("fload_flags", 32'(oFlags), 32'hF0);
        checkOutput("fload_data", 32'(oWrData), 32'h00);
        stepClock(acc);

        // ADD 15+27 then DAA.
        applyStimulus(1, 1, 4'd0, 8'h15, 8'h27, 3'd7, 0, 0, 8'h00);
        stepClock(acc);
        applyStimulus(1, 1, 4'd15, 8'h3C, 8'h00, 3'd7, 0, 0, 8'h00);
        stepClock(acc);
        applyStimulus(1, 0, 4'd0, 8'h00, 8'h00, 3'd0, 0, 0, 8'h00);
`ifdef CPU_ALU_DAA_EN
        checkOutput("daa_data", 32'(oWrData), 32'h42);
        checkOutput("daa_carry", 32'(oFlags[4]), 32'd0);
`else
        checkOutput("daa_nop_data", 32'(oWrData), 32'h3C);
        checkOutput("daa_nop_flags", 32'(oFlags), 32'h00);
`endif
        checkOutput("daa_wr_en", 32'(oWrEn), 32'd1);
        stepClock(acc);

        // Randomized traffic; a refused request is held stable until accepted.
        pending = 0;
        hOp = 0; hA = 0; hB = 0; hDst = 0;
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 49) != 0);
            if (!pending) begin
                hOp  = 4'($urandom_range(0, 15));
                hA   = 8'($urandom);
                hB   = 8'($urandom);
                hDst = 3'($urandom_range(0, 7));
                v    = ($urandom_range(0, 3) != 0);
            end else begin
                v = 1;
            end
            s  = ($urandom_range(0, 2) == 0);
            fw = ($urandom_range(0, 9) == 0);
            fd = 8'($urandom);
            applyStimulus(r, v, hOp, hA, hB, hDst, s, fw, fd);
            stepClock(acc);
            pending = v && !acc && r;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_alu_stage.md
Name: cpu_alu_stage

Overview:
- Execute stage directly downstream of the CPU register file.
- Consumes the two 8-bit read operands and an op code, and computes SM83 8-bit ALU results.
- Registers the result into a one-entry output stage that drives the register-file write port (wr_sel, wr_en, wr_data).
- Owns the architectural flag register F (Z N H C). Supports downstream stall and an external F load (POP AF).

Parameters:
- OP_W, 4, op code width.
- REG_SEL_W, 3, register select width (B=0 C=1 D=2 E=3 H=4 L=5 (HL)=6 A=7).

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  synchronous reset, active-low (0 = reset).
- i_valid  in  1  op request valid.
- o_ready  out  1  stage can accept an op this cycle.
- i_op  in  4  alu_op_e code.
- i_op_a  in  8  operand A (unary ops operate on this).
- i_op_b  in  8  operand B.
- i_dst  in  3  destination register select.
- i_stall  in  1  downstream cannot take the write this cycle.
- o_reg_wr_sel  out  3  registered destination.
- o_reg_wr_en  out  1  registered write strobe.
- o_reg_wr_data  out  8  registered result.
- i_f_wr_en  in  1  external F load strobe.
- i_f_wr_data  in  8  external F value.
- o_flags  out  8  current F; bits [3:0] always 0.

Behaviour:
- Reset (i_rst=0 at edge):
  - out_valid=0, o_reg_wr_en=0, o_reg_wr_sel=0, o_reg_wr_data=0, o_flags=8'h00.
  - Reset wins over every other input, including in the middle of a stall.
- Output stage has two states: EMPTY (out_valid=0) and FULL (out_valid=1).
- o_ready = !out_valid || !i_stall. It is combinational and never depends on i_valid.
- Accept when i_valid && o_ready:
  - Next cycle: out_valid=1, and the registered result, destination and write-enable load.
  - Latency is exactly 1 cycle.
- o_reg_wr_en = out_valid && wr_allowed && !i_stall. wr_allowed is 0 for CP, 1 for all other ops.
- FULL with i_stall=1: outputs hold exactly and o_ready=0.
- FULL with i_stall=0 and no new accept: goes to EMPTY.
- Accept while FULL and not stalled: back-to-back; the stage stays FULL with the new op.
- Flags update at accept time, so back-to-back ADC/SBC see the previous op's carry.
- Op codes and flags (Z = result==0 unless stated; S = "same as before"):
  - 0 ADD: N=0; H=carry from bit 3; C=carry from bit 7.
  - 1 ADC: as ADD, with carry-in = F.C.
  - 2 SUB: N=1; H=borrow from bit 4; C=borrow.
  - 3 SBC: as SUB, with borrow-in = F.C.
  - 4 AND: N=0, H=1, C=0.
  - 5 XOR and 6 OR: N=0, H=0, C=0.
  - 7 CP: same flags as SUB; no register write.
  - 8 INC and 9 DEC (on A): N=0 for INC, N=1 for DEC; H per nibble carry/borrow; C=S.
  - 10 RLC, 11 RRC, 12 RL, 13 RR (on A): Z from result; N=0, H=0; C=bit shifted out. RL and RR shift F.C in.
  - 14 CPL (on A): result=~A; N=1, H=1; Z=S, C=S.
  - 15 DAA: see Optional Feature.
- Arithmetic uses 9-bit sums for C and 5-bit nibble sums for H. Results truncate to 8 bits; 8'hFF+1 wraps to 00 with Z=1.
- i_f_wr_en in the same cycle as an accept: F loads {i_f_wr_data[7:4],4'h0}. The accepted op's flag update is dropped, but its result is still registered.
- i_valid=1 with o_ready=0: nothing changes. The requester must hold i_valid and all request fields stable until accepted.

Optional Feature:
- Macro: CPU_ALU_DAA_EN.
- Defined:
  - Op 15 performs SM83 DAA on A, using F.N, F.H and F.C.
  - Z from result; H=0; N=S; C=S or set when the high correction (0x60) is applied.
- Undefined: op 15 behaves as a NOP. Result=A, F unchanged, write still issued.

Decomposition:
- Package cpu_pkg holds:
  - alu_op_e (4-bit enum);
  - reg_sel_e (B..A encodings);
  - flag bit index constants FLAG_Z=7, FLAG_N=6, FLAG_H=5, FLAG_C=4.
- One sub-module, cpu_alu_core: purely combinational op/operands/F-in to result/F-out/wr_allowed.
- cpu_alu_stage keeps the output register, handshake and F register.

Test Plan:
- Reset, then ADD A=8'h3A, B=8'hC6, dst=7. Next cycle: o_reg_wr_en=1, wr_sel=7, wr_data=8'h00, F=8'hB0 (Z H C).
- ADD 8'hFF+8'h01 (sets C), then ADC 8'h10+8'h20 back-to-back: second result 8'h31, F=8'h00.
- CP A=8'h10, B=8'h10: wr_en stays 0, F=8'hC0. Then SUB 8'h10-8'h20: data=8'hF0, F=8'h50.
- Accept INC with i_stall=1 held 3 cycles: o_ready=0, outputs frozen, wr_en=0. Release stall: wr_en=1 for exactly one cycle with the original data.
- i_f_wr_en=1, data=8'hFF, coincident with accepted AND 8'hF0&8'h0F: F=8'hF0, wr_data=8'h00.
- With CPU_ALU_DAA_EN, ADD 8'h15+8'h27 then DAA: wr_data=8'h42, F.C=0. Without the macro, DAA returns 8'h3C and F is unchanged.
